// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic tile sequencer and its bench.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Cycles the PE grid must be enabled so the last skewed operand pair
    // reaches the far corner PE and is accumulated.
    function automatic int compute_cycles(input int k, input int rows,
                                          input int cols, input int pe_latency);
        return k + rows + cols - 1 + pe_latency;
    endfunction

endpackage

// File: rtl/systolic_tile_sequencer.sv
// Sequences one matrix tile through the systolic array: resets and starts the
// row/column PISO feeders, enables the PE grid for the drain time of the skewed
// operands, then holds the result until the collector acknowledges it.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a tile request (req_ready high)
// FLUSH | PISOs in reset; PE accumulators cleared unless accumulating
// LOAD  | PISOs load the stable operand buses and start shifting
// RUN   | PE grid enabled for COMPUTE_CYCLES cycles
// HOLD  | results complete in the accumulators, waiting for res_ready
module systolic_tile_sequencer #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int K           = 4,
    parameter int PE_LATENCY  = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_accumulate,
    output logic                   feed_rst,
    output logic                   feed_start,
    output logic                   pe_clear,
    output logic                   pe_en,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] tile_count
);
    import systolic_pkg::*;

    localparam int COMPUTE_CYCLES = compute_cycles(K, ROWS, COLS, PE_LATENCY);
    localparam int CNT_W          = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             acc_q;
    logic             flush_dec;
    logic             handshake;

    assign handshake = (state == HOLD) && res_ready;

    // State, RUN counter, accumulate flag and completed-tile counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc_q      <= 1'b0;
            tile_count <= '0;
        end else begin
            state <= state_nx;
            if ((state == IDLE) && req_valid) begin
                acc_q <= req_accumulate;
            end
            if (state == RUN) begin
                cnt <= cnt + 1'b1;
            end else if (handshake) begin
                cnt <= '0;
            end
            if (handshake) begin
                tile_count <= tile_count + 1'b1;
            end
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        flush_dec  = 1'b0;
        feed_start = 1'b0;
        pe_clear   = 1'b0;
        pe_en      = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                flush_dec = 1'b1;
                pe_clear  = !acc_q;
                state_nx  = LOAD;
            end
            LOAD: begin
                feed_start = 1'b1;
                state_nx   = RUN;
            end
            RUN: begin
                pe_en = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // PISOs are held in reset together with the controller so both leave
    // reset in a consistent, start-ready condition.
    assign feed_rst = rst | flush_dec;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed bench for systolic_tile_sequencer with a timeline model of one tile
// (cycles since accept) checked against the DUT on every cycle.
module tb_systolic_tile_sequencer;
    import systolic_pkg::*;

    localparam int CW = 4;
    localparam int CC = compute_cycles(4, 4, 4, 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_accumulate = 1'b0;
    logic          res_ready = 1'b0;
    logic          req_ready, feed_rst, feed_start, pe_clear, pe_en, res_valid, busy;
    logic [CW-1:0] tile_count;

    systolic_tile_sequencer #(
        .ROWS(4), .COLS(4), .K(4), .PE_LATENCY(1), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_accumulate(req_accumulate),
        .feed_rst(feed_rst), .feed_start(feed_start), .pe_clear(pe_clear), .pe_en(pe_en),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .tile_count(tile_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: a tile is a timeline indexed by cycles since its accept edge.
    // t=1 flush, t=2 load, t=3..CC+2 run, t=CC+3 hold until res_ready.
    bit started = 1'b0;
    bit m_busy  = 1'b0;
    int m_t     = 0;
    int m_count = 0;
    bit m_acc   = 1'b0;

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        if (rst) begin
            m_busy = 1'b0; m_t = 0; m_count = 0; m_acc = 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1'b1; m_t = 1; m_acc = req_accumulate;
            end
        end else if (m_t == CC + 3) begin
            if (res_ready) begin
                m_busy = 1'b0; m_t = 0; m_count = (m_count + 1) % (1 << CW);
            end
        end else begin
            m_t++;
        end
    end

    int n_pe_en, n_feed_rst, n_feed_start, n_pe_clear, n_res_valid;

    task automatic clear_counts();
        n_pe_en = 0; n_feed_rst = 0; n_feed_start = 0; n_pe_clear = 0; n_res_valid = 0;
    endtask

    // Per-cycle compare against the model, plus event tallies for literal checks.
    always @(negedge clk) begin
        if (started) begin
            check("req_ready",  32'(req_ready),  32'(!m_busy));
            check("busy",       32'(busy),       32'(m_busy));
            check("feed_rst",   32'(feed_rst),   32'(rst || (m_busy && m_t == 1)));
            check("feed_start", 32'(feed_start), 32'(m_busy && m_t == 2));
            check("pe_clear",   32'(pe_clear),   32'(m_busy && m_t == 1 && !m_acc));
            check("pe_en",      32'(pe_en),      32'(m_busy && m_t >= 3 && m_t <= CC + 2));
            check("res_valid",  32'(res_valid),  32'(m_busy && m_t == CC + 3));
            check("tile_count", 32'(tile_count), 32'(m_count));
            if (feed_start && feed_rst) check("start_vs_rst", 32'(1), 32'(0));
        end
        if (pe_en)      n_pe_en++;
        if (feed_rst)   n_feed_rst++;
        if (feed_start) n_feed_start++;
        if (pe_clear)   n_pe_clear++;
        if (res_valid)  n_res_valid++;
    end

    task automatic wait_res_valid(output int edges);
        edges = 0;
        while (!res_valid && edges < 40) begin
            step();
            edges++;
        end
        if (!res_valid) check("timeout_res_valid", 32'(0), 32'(1));
    endtask

    initial begin
        int e;
        int prev;
        int last;
        int k;
        clear_counts();

        // Reset held for three cycles.
        repeat (3) step();
        check("rst_feed_rst", 32'(feed_rst), 32'(1));
        rst = 1'b0;
        step();
        check("rst_req_ready",  32'(req_ready),  32'(1));
        check("rst_busy",       32'(busy),       32'(0));
        check("rst_feed_rst_lo",32'(feed_rst),   32'(0));
        check("rst_res_valid",  32'(res_valid),  32'(0));
        check("rst_tile_count", 32'(tile_count), 32'(0));

        // Reset while RUN with cnt=5.
        req_valid = 1'b1; req_accumulate = 1'b0; res_ready = 1'b1;
        step();                       // E0 accept
        req_valid = 1'b0;
        repeat (7) step();            // E1..E7
        check("mid_pe_en_before", 32'(pe_en), 32'(1));
        rst = 1'b1;
        step();                       // E8
        clear_counts();
        check("mid_busy",      32'(busy),      32'(0));
        check("mid_pe_en",     32'(pe_en),     32'(0));
        check("mid_req_ready", 32'(req_ready), 32'(1));
        rst = 1'b0;
        repeat (20) step();
        check("mid_no_res_valid", 32'(n_res_valid), 32'(0));
        check("mid_no_pe_en",     32'(n_pe_en),     32'(0));
        check("mid_tile_count",   32'(tile_count),  32'(0));

        // Single tile, clearing accumulators; flag flipped after accept.
        clear_counts();
        req_valid = 1'b1; req_accumulate = 1'b0; res_ready = 1'b1;
        step();
        req_valid = 1'b0; req_accumulate = 1'b1;
        wait_res_valid(e);
        check("single_res_valid_edge", 32'(e), 32'(14));
        repeat (3) step();
        check("single_pe_en_cycles", 32'(n_pe_en),      32'(12));
        check("single_feed_rst",     32'(n_feed_rst),   32'(1));
        check("single_feed_start",   32'(n_feed_start), 32'(1));
        check("single_pe_clear",     32'(n_pe_clear),   32'(1));
        check("single_res_valid",    32'(n_res_valid),  32'(1));
        check("single_tile_count",   32'(tile_count),   32'(1));

        // Accumulating tile; flag dropped after accept.
        clear_counts();
        req_valid = 1'b1; req_accumulate = 1'b1;
        step();
        req_valid = 1'b0; req_accumulate = 1'b0;
        wait_res_valid(e);
        repeat (3) step();
        check("acc_pe_clear",   32'(n_pe_clear), 32'(0));
        check("acc_pe_en",      32'(n_pe_en),    32'(12));
        check("acc_tile_count", 32'(tile_count), 32'(2));

        // Backpressure: res_ready low for 5 HOLD cycles, stray request in HOLD.
        clear_counts();
        res_ready = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        wait_res_valid(e);
        check("bp_res_valid_edge", 32'(e), 32'(14));
        step();                       // E15
        req_valid = 1'b1;
        step();                       // E16
        check("bp_req_ready", 32'(req_ready), 32'(0));
        check("bp_pe_en",     32'(pe_en),     32'(0));
        req_valid = 1'b0;
        repeat (3) step();            // E17..E19
        res_ready = 1'b1;
        step();                       // E20 handshake
        check("bp_busy_after", 32'(busy), 32'(0));
        repeat (3) step();
        check("bp_res_valid_cycles", 32'(n_res_valid), 32'(6));
        check("bp_feed_rst",         32'(n_feed_rst),  32'(1));
        check("bp_tile_count",       32'(tile_count),  32'(3));

        // 17 back-to-back tiles with a 4-bit counter.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("wrap_start_count", 32'(tile_count), 32'(0));
        req_valid = 1'b1; res_ready = 1'b1; req_accumulate = 1'b1;
        prev = 0;
        for (int i = 0; i < 17; i++) begin
            last = int'(tile_count);
            k = 0;
            while (int'(tile_count) == last && k < 40) begin
                step();
                k++;
            end
            if (i == 16) req_valid = 1'b0;
            if (k >= 40) check("timeout_wrap", 32'(0), 32'(1));
            check("wrap_count", 32'(tile_count), 32'((i + 1) % 16));
            if (i > 0) check("wrap_period", 32'(cyc - prev), 32'(16));
            prev = cyc;
        end
        repeat (20) step();
        check("wrap_final_count", 32'(tile_count), 32'(1));
        check("wrap_final_busy",  32'(busy),       32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
